// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Drives an external Montgomery multiplier over a start/done handshake.
module modexp_ctrl #(
  parameter int N   = 1024,
  parameter int E_W = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [N-1:0]         in_x,
  input  logic [E_W-1:0]       in_e,
  input  logic [$clog2(E_W):0] in_e_bits,
  input  logic [N-1:0]         in_m,
  input  logic [N-1:0]         in_r,
  input  logic [N-1:0]         in_r2,
  output logic                 mm_start,
  output logic [N-1:0]         mm_a,
  output logic [N-1:0]         mm_b,
  output logic [N-1:0]         mm_m,
  input  logic [N-1:0]         mm_result,
  input  logic                 mm_done,
  output logic [N-1:0]         result,
  output logic                 done,
  output logic                 busy
);

  localparam int EBW  = $clog2(E_W) + 1;
  localparam int IDXW = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [EBW-1:0] EB_MAX = EBW'(E_W);
  localparam logic [N-1:0]   ONE    = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    CONV_IN,
    SQR,
    MUL,
    CONV_OUT,
    FINISH
  } state_t;

  state_t          state, state_nx;
  logic            wait_q, wait_nx;
  logic            accept, op_done, idx_dec;
  logic [N-1:0]    x_q, r2_q, m_q, xt_q, a_q, result_q;
  logic [E_W-1:0]  e_q;
  logic [IDXW-1:0] idx_q;
  logic            ez_q;
  logic [EBW-1:0]  eb_clamped;

  assign eb_clamped = (in_e_bits > EB_MAX) ? EB_MAX : in_e_bits;

  assign result = result_q;
  assign mm_m   = m_q;
  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      wait_q <= 1'b0;
    end else begin
      state  <= state_nx;
      wait_q <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_q;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    accept   = 1'b0;
    op_done  = 1'b0;
    idx_dec  = 1'b0;

    case (state)
      CONV_IN:  begin mm_a = x_q; mm_b = r2_q; end
      SQR:      begin mm_a = a_q; mm_b = a_q;  end
      MUL:      begin mm_a = a_q; mm_b = xt_q; end
      CONV_OUT: begin mm_a = a_q; mm_b = ONE;  end
      default:  ;
    endcase

    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CONV_IN;
          wait_nx  = 1'b0;
        end
      end
      CONV_IN, SQR, MUL, CONV_OUT: begin
        // mm_done is only honoured once the issue cycle has passed
        if (!wait_q) begin
          mm_start = 1'b1;
          wait_nx  = 1'b1;
        end else if (mm_done) begin
          op_done = 1'b1;
          wait_nx = 1'b0;
          case (state)
            CONV_IN: state_nx = ez_q ? CONV_OUT : SQR;
            SQR: begin
              if (e_q[idx_q]) begin
                state_nx = MUL;
              end else if (idx_q == '0) begin
                state_nx = CONV_OUT;
              end else begin
                idx_dec  = 1'b1;
                state_nx = SQR;
              end
            end
            MUL: begin
              if (idx_q == '0) begin
                state_nx = CONV_OUT;
              end else begin
                idx_dec  = 1'b1;
                state_nx = SQR;
              end
            end
            default: state_nx = FINISH;
          endcase
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q      <= '0;
      r2_q     <= '0;
      m_q      <= '0;
      xt_q     <= '0;
      a_q      <= '0;
      result_q <= '0;
      e_q      <= '0;
      idx_q    <= '0;
      ez_q     <= 1'b0;
    end else begin
      if (accept) begin
        x_q   <= in_x;
        r2_q  <= in_r2;
        m_q   <= in_m;
        a_q   <= in_r;
        e_q   <= in_e;
        ez_q  <= (eb_clamped == '0);
        idx_q <= IDXW'(eb_clamped - EBW'(1));
      end
      if (op_done) begin
        case (state)
          CONV_IN:  xt_q     <= mm_result;
          SQR, MUL: a_q      <= mm_result;
          CONV_OUT: result_q <= mm_result;
          default:  ;
        endcase
      end
      if (idx_dec) begin
        idx_q <= idx_q - IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery multiplier plus an
// arithmetic reference for results, call counts and operand sequences.
module tb_modexp_ctrl;

  localparam int N      = 8;
  localparam int E_W    = 8;
  localparam int MM_LAT = 7;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [N-1:0] in_x, in_m, in_r, in_r2;
  logic [E_W-1:0] in_e;
  logic [3:0]   in_e_bits;
  logic         mm_start;
  logic [N-1:0] mm_a, mm_b, mm_m, mm_result;
  logic         mm_done;
  logic [N-1:0] result;
  logic         done, busy;

  modexp_ctrl #(.N(N), .E_W(E_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_bits(in_e_bits),
    .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model and operand log; all activity on the falling edge.
  logic         mdone = 1'b0;
  logic         stray_done = 1'b0;
  logic [N-1:0] mres = '0;
  logic [N-1:0] la, lb, lm;
  bit           pend = 1'b0;
  bit           unstable = 1'b0;
  int           cnt = 0;
  int           n_mm = 0;
  logic [N-1:0] obs_a[$], obs_b[$], obs_m[$];

  assign mm_done   = mdone | stray_done;
  assign mm_result = mres;

  function automatic logic [N-1:0] mont(int a, int b, int m);
    int rinv = 0;
    for (int t = 1; t < m; t++) if ((256 * t) % m == 1) rinv = t;
    return N'(((a * b) % m) * rinv % m);
  endfunction

  always @(negedge clk) begin
    mdone = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mdone = 1'b1;
        mres  = mont(int'(la), int'(lb), int'(lm));
        pend  = 1'b0;
      end else if (busy && (mm_a !== la || mm_b !== lb || mm_m !== lm)) begin
        unstable = 1'b1;
      end
    end
    if (mm_start === 1'b1) begin
      obs_a.push_back(mm_a);
      obs_b.push_back(mm_b);
      obs_m.push_back(mm_m);
      la = mm_a; lb = mm_b; lm = mm_m;
      pend = 1'b1;
      cnt  = MM_LAT;
      n_mm = n_mm + 1;
    end
  end

  // Reference: result by right-to-left binary powering, operand sequence
  // from the left-to-right algorithm expressed in normal-domain arithmetic.
  int n_checks = 0;
  int n_fail   = 0;
  int ref_a[$], ref_b[$];

  function automatic int modpow(int x, int e, int eb, int m);
    int r = 1 % m;
    int base = x % m;
    int ebe = (eb > E_W) ? E_W : eb;
    for (int i = 0; i < ebe; i++) begin
      if (((e >> i) & 1) == 1) r = (r * base) % m;
      base = (base * base) % m;
    end
    return r;
  endfunction

  function automatic void build_ref(int x, int e, int eb, int m);
    int ebe = (eb > E_W) ? E_W : eb;
    int an  = 1 % m;
    int xt  = (x * 256) % m;
    int r   = 256 % m;
    ref_a.delete();
    ref_b.delete();
    ref_a.push_back(x);
    ref_b.push_back((r * r) % m);
    for (int i = ebe - 1; i >= 0; i--) begin
      ref_a.push_back((an * 256) % m);
      ref_b.push_back((an * 256) % m);
      an = (an * an) % m;
      if (((e >> i) & 1) == 1) begin
        ref_a.push_back((an * 256) % m);
        ref_b.push_back(xt);
        an = (an * x) % m;
      end
    end
    ref_a.push_back((an * 256) % m);
    ref_b.push_back(1);
  endfunction

  task automatic do_start(input int x, input int e, input int eb, input int m);
    @(negedge clk);
    in_x      = N'(x);
    in_e      = E_W'(e);
    in_e_bits = 4'(eb);
    in_m      = N'(m);
    in_r      = N'(256 % m);
    in_r2     = N'(((256 % m) * (256 % m)) % m);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(output bit to, output int busy_cyc);
    to = 1'b1;
    busy_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ops(input int target);
    for (int i = 0; i < 500 && n_mm < target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0;
    in_x = '0; in_e = '0; in_e_bits = '0; in_m = '0; in_r = '0; in_r2 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mm_start, mm_a, mm_b, mm_m, result, done, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mm_start=%b mm_a=%0d mm_b=%0d mm_m=%0d result=%0d done=%b busy=%b, expected all 0",
               mm_start, mm_a, mm_b, mm_m, result, done, busy);
    end
    // start together with reset low must not be accepted
    in_x = 8'd2; in_e = 8'd5; in_e_bits = 4'd3; in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mm_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_start: got busy=%b mm_start=%b, expected 0 0", busy, mm_start);
    end
  endtask

  task automatic test_basic();
    int base = obs_a.size();
    int nb = n_mm;
    int bc;
    bit to;
    build_ref(2, 5, 3, 13);
    do_start(2, 5, 3, 13);
    n_checks++;
    if (busy !== 1'b1 || mm_start !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_latency: got busy=%b mm_start=%b, expected 1 1", busy, mm_start);
    end
    wait_done(to, bc);
    n_checks++;
    if (to || result !== 8'd6) begin
      n_fail++;
      $display("FAIL basic_result: got %0d (timeout=%0d), expected 6", result, to);
    end
    n_checks++;
    if (n_mm - nb != 7) begin
      n_fail++;
      $display("FAIL basic_calls: got %0d, expected 7", n_mm - nb);
    end
    n_checks++;
    if (bc != 7 * (MM_LAT + 1) + 1) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, 7 * (MM_LAT + 1) + 1);
    end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (obs_a.size() <= base + k || obs_a[base+k] !== N'(ref_a[k]) ||
          obs_b[base+k] !== N'(ref_b[k]) || obs_m[base+k] !== 8'd13) begin
        n_fail++;
        $display("FAIL basic_op%0d: got a=%0d b=%0d m=%0d, expected a=%0d b=%0d m=13",
                 k, (obs_a.size() > base + k) ? obs_a[base+k] : 8'hxx,
                 (obs_b.size() > base + k) ? obs_b[base+k] : 8'hxx,
                 (obs_m.size() > base + k) ? obs_m[base+k] : 8'hxx, ref_a[k], ref_b[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got done=%b busy=%b one cycle later, expected 0 0", done, busy);
    end
  endtask

  task automatic test_all_ones();
    int nb = n_mm;
    int bc;
    bit to;
    do_start(2, 8'hFF, 8, 13);
    wait_done(to, bc);
    n_checks++;
    if (to || result !== 8'd8) begin
      n_fail++;
      $display("FAIL ones_result: got %0d (timeout=%0d), expected 8", result, to);
    end
    n_checks++;
    if (n_mm - nb != 18) begin
      n_fail++;
      $display("FAIL ones_calls: got %0d, expected 18", n_mm - nb);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_done_width: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_zero_bits();
    int nb = n_mm;
    int bc;
    bit to;
    do_start(5, int'($urandom_range(255)), 0, 13);
    wait_done(to, bc);
    n_checks++;
    if (to || result !== 8'd1 || n_mm - nb != 2) begin
      n_fail++;
      $display("FAIL zero_bits: got result=%0d calls=%0d timeout=%0d, expected result=1 calls=2",
               result, n_mm - nb, to);
    end
  endtask

  task automatic test_input_change();
    int base = obs_m.size();
    int bc;
    bit to;
    bit m_ok = 1'b1;
    do_start(0, 5, 3, 13);
    in_x = N'($urandom_range(255)); in_e = E_W'($urandom_range(255));
    in_e_bits = 4'($urandom_range(15)); in_m = 8'd211; in_r = N'($urandom);
    in_r2 = N'($urandom);
    wait_done(to, bc);
    n_checks++;
    if (to || result !== 8'd0) begin
      n_fail++;
      $display("FAIL x_zero_result: got %0d (timeout=%0d), expected 0", result, to);
    end
    for (int k = base; k < obs_m.size(); k++) if (obs_m[k] !== 8'd13) m_ok = 1'b0;
    n_checks++;
    if (!m_ok || obs_m.size() - base != 7) begin
      n_fail++;
      $display("FAIL latched_modulus: got calls=%0d modulus_ok=%0d, expected calls=7 modulus_ok=1",
               obs_m.size() - base, m_ok);
    end
  endtask

  task automatic test_start_while_busy();
    int base = obs_a.size();
    int nb = n_mm;
    int bc;
    bit to;
    bit ops_ok = 1'b1;
    build_ref(2, 5, 3, 13);
    do_start(2, 5, 3, 13);
    wait_ops(nb + 2);
    repeat (2) @(negedge clk);
    in_x = 8'd7; in_e = 8'hFF; in_e_bits = 4'd8; in_m = 8'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(to, bc);
    for (int k = 0; k < 7; k++)
      if (obs_a.size() <= base + k || obs_a[base+k] !== N'(ref_a[k]) || obs_b[base+k] !== N'(ref_b[k]))
        ops_ok = 1'b0;
    n_checks++;
    if (to || result !== 8'd6 || n_mm - nb != 7 || !ops_ok) begin
      n_fail++;
      $display("FAIL start_while_busy: got result=%0d calls=%0d ops_ok=%0d timeout=%0d, expected 6 7 1 0",
               result, n_mm - nb, ops_ok, to);
    end
    @(negedge clk);
    nb = n_mm;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_mm != nb || result !== 8'd6 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done_idle: got calls=%0d result=%0d busy=%b done=%b, expected 0 6 0 0",
               n_mm - nb, result, busy, done);
    end
  endtask

  task automatic test_abort();
    int nb = n_mm;
    int bc;
    bit to;
    do_start(2, 5, 3, 13);
    wait_ops(nb + 3);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_checks++;
    if ({mm_start, mm_a, mm_b, mm_m, result, done, busy} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got mm_start=%b mm_a=%0d mm_b=%0d mm_m=%0d result=%0d done=%b busy=%b, expected all 0",
               mm_start, mm_a, mm_b, mm_m, result, done, busy);
    end
    for (int i = 0; i < 50 && pend; i++) @(negedge clk);
    nb = n_mm;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pend || n_mm != nb || busy !== 1'b0 || result !== 8'd0) begin
      n_fail++;
      $display("FAIL late_done_ignored: got pending=%0d calls=%0d busy=%b result=%0d, expected 0 0 0 0",
               pend, n_mm - nb, busy, result);
    end
    do_start(2, 5, 3, 13);
    wait_done(to, bc);
    n_checks++;
    if (to || result !== 8'd6 || n_mm - nb != 7) begin
      n_fail++;
      $display("FAIL restart_after_abort: got result=%0d calls=%0d timeout=%0d, expected 6 7 0",
               result, n_mm - nb, to);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int m  = int'($urandom_range(3, 255)) | 1;
      int x  = int'($urandom_range(m - 1));
      int e  = int'($urandom_range(255));
      int eb = int'($urandom_range(15));
      int ebe = (eb > E_W) ? E_W : eb;
      int pc = 0;
      int calls;
      int base = obs_a.size();
      int nb = n_mm;
      int exp_res = modpow(x, e, eb, m);
      int bc;
      bit to;
      bit ops_ok = 1'b1;
      for (int i = 0; i < ebe; i++) pc += (e >> i) & 1;
      calls = 2 + ebe + pc;
      build_ref(x, e, eb, m);
      do_start(x, e, eb, m);
      wait_done(to, bc);
      n_checks++;
      if (to || result !== N'(exp_res)) begin
        n_fail++;
        $display("FAIL rand%0d_result: x=%0d e=%0d eb=%0d m=%0d got %0d (timeout=%0d), expected %0d",
                 it, x, e, eb, m, result, to, exp_res);
      end
      for (int k = 0; k < calls; k++)
        if (obs_a.size() <= base + k || obs_a[base+k] !== N'(ref_a[k]) ||
            obs_b[base+k] !== N'(ref_b[k]) || obs_m[base+k] !== N'(m))
          ops_ok = 1'b0;
      n_checks++;
      if (n_mm - nb != calls || !ops_ok || bc != calls * (MM_LAT + 1) + 1) begin
        n_fail++;
        $display("FAIL rand%0d_sequence: got calls=%0d ops_ok=%0d busy_cycles=%0d, expected %0d 1 %0d",
                 it, n_mm - nb, ops_ok, bc, calls, calls * (MM_LAT + 1) + 1);
      end
    end
  endtask

  task automatic test_operand_stability();
    n_checks++;
    if (unstable) begin
      n_fail++;
      $display("FAIL operand_stability: got operands changed during wait=%0d, expected 0", unstable);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero_bits();
    test_input_change();
    test_start_while_busy();
    test_abort();
    test_random();
    test_operand_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
